dftm_sdram_arbiter: RTL and testbench

- Shares one SDRAM host interface between two requesters.
  - Port 0: the dftm host path.
  - Port 1: a background engine, e.g. scrubber or migration.
- Sits between the requesters and the SDRAM controller's host interface.
- Serialises whole transactions and routes read data and done back to the winner.
- Arbitration is round-robin, or p0-priority with a starvation limit.
- A watchdog recovers a transaction the SDRAM never completes.

---
 rtl/dftm_sdram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dftm_sdram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dftm_sdram_arbiter.sv
// Two-port arbiter in front of one SDRAM host interface: serialises whole transactions,
// routes read data/done back to the winner, and aborts transactions the SDRAM never finishes.
module dftm_sdram_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int PRIO_P0  = 0,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              p0_rd_i,
    input  logic              p0_wr_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_done_o,
    output logic              p0_err_o,
    input  logic              p1_rd_i,
    input  logic              p1_wr_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_done_o,
    output logic              p1_err_o,
    output logic              sdram_rd_o,
    output logic              sdram_wr_o,
    output logic [ADDR_W-1:0] sdram_addr_o,
    output logic [DATA_W-1:0] sdram_data_o,
    input  logic [DATA_W-1:0] sdram_data_i,
    input  logic              sdram_done_i,
    output logic              grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

    // The timer holds the number of completed BUSY cycles, so the abort fires on the
    // TIMEOUT-th BUSY cycle and the command stays up for exactly TIMEOUT cycles.
    localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT - 1);
    localparam logic [3:0] WAIT_MAX   = 4'(MAX_WAIT);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last_grant;
    logic [3:0]  r_wait_cnt;
    logic [9:0]  r_timer;

    logic        w_req0;
    logic        w_req1;
    logic        w_win;
    logic        w_win_rd;
    logic        w_timer_hit;

    assign w_req0      = p0_rd_i | p0_wr_i;
    assign w_req1      = p1_rd_i | p1_wr_i;
    assign w_win_rd    = w_win ? p1_rd_i : p0_rd_i;
    assign w_timer_hit = (r_timer == TIMER_LAST);
    assign busy_o      = (r_state != ST_IDLE);

    always_comb begin
        w_win = 1'b0;
        if (PRIO_P0 != 0) begin
            w_win = w_req1 && (!w_req0 || (r_wait_cnt == WAIT_MAX));
        end else if (w_req0 && w_req1) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = w_req1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_req0 || w_req1)              w_next_state = ST_BUSY;
            ST_BUSY:    if (sdram_done_i || w_timer_hit)   w_next_state = ST_RELEASE;
            ST_RELEASE:                                     w_next_state = ST_IDLE;
            default:                                        w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_grant <= 1'b1;
            r_wait_cnt   <= '0;
            r_timer      <= '0;
            sdram_rd_o   <= 1'b0;
            sdram_wr_o   <= 1'b0;
            sdram_addr_o <= '0;
            sdram_data_o <= '0;
            grant_o      <= 1'b0;
            timeout_o    <= 1'b0;
            p0_data_o    <= '0;
            p0_done_o    <= 1'b0;
            p0_err_o     <= 1'b0;
            p1_data_o    <= '0;
            p1_done_o    <= 1'b0;
            p1_err_o     <= 1'b0;
        end else begin
            p0_done_o <= 1'b0;
            p0_err_o  <= 1'b0;
            p1_done_o <= 1'b0;
            p1_err_o  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 || w_req1) begin
                        sdram_addr_o <= w_win ? p1_addr_i : p0_addr_i;
                        sdram_data_o <= w_win ? p1_data_i : p0_data_i;
                        sdram_rd_o   <= w_win_rd;
                        sdram_wr_o   <= ~w_win_rd;
                        grant_o      <= w_win;
                        r_last_grant <= w_win;
                        r_timer      <= '0;
                        if (PRIO_P0 != 0) begin
                            if (w_win)
                                r_wait_cnt <= '0;
                            else if (w_req1 && (r_wait_cnt != WAIT_MAX))
                                r_wait_cnt <= r_wait_cnt + 4'd1;
                        end
                    end
                end
                ST_BUSY: begin
                    r_timer <= r_timer + 10'd1;
                    if (sdram_done_i) begin
                        sdram_rd_o <= 1'b0;
                        sdram_wr_o <= 1'b0;
                        if (grant_o) begin
                            p1_done_o <= 1'b1;
                            if (sdram_rd_o) p1_data_o <= sdram_data_i;
                        end else begin
                            p0_done_o <= 1'b1;
                            if (sdram_rd_o) p0_data_o <= sdram_data_i;
                        end
                    end else if (w_timer_hit) begin
                        sdram_rd_o <= 1'b0;
                        sdram_wr_o <= 1'b0;
                        timeout_o  <= 1'b1;
                        if (grant_o) begin
                            p1_done_o <= 1'b1;
                            p1_err_o  <= 1'b1;
                            p1_data_o <= '0;
                        end else begin
                            p0_done_o <= 1'b1;
                            p0_err_o  <= 1'b1;
                            p0_data_o <= '0;
                        end
                    end
                end
                ST_RELEASE: r_timer <= '0;
                default:    r_timer <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dftm_sdram_arbiter.sv
// Scoreboard bench: a round-robin instance (TIMEOUT=8) runs directed transactions and a
// p0-priority instance (MAX_WAIT=2) checks the starvation-guarded grant order.
module tb_dftm_sdram_arbiter;

    typedef struct packed {
        logic        grant;
        logic        rd;
        logic        wr;
        logic [23:0] addr;
        logic [15:0] data;
    } iss_t;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
        logic        err;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: round-robin, short timeout
    logic        rst_n = 1'b1;
    logic        p0_rd = 0, p0_wr = 0, p1_rd = 0, p1_wr = 0;
    logic [23:0] p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_wdata = '0, p1_wdata = '0;
    logic [15:0] p0_rdata, p1_rdata;
    logic        p0_done, p0_err, p1_done, p1_err;
    logic        sd_rd, sd_wr, sd_done = 0;
    logic [23:0] sd_addr;
    logic [15:0] sd_wdata, sd_rdata = '0;
    logic        grant, busy, tmo;

    // Instance B: p0 priority with starvation guard
    logic        rst_n_b = 1'b1;
    logic        p0_wr_b = 0, p1_wr_b = 0;
    logic [15:0] p0_rdata_b, p1_rdata_b;
    logic        p0_done_b, p0_err_b, p1_done_b, p1_err_b;
    logic        sd_rd_b, sd_wr_b, sd_done_b = 0;
    logic [23:0] sd_addr_b;
    logic [15:0] sd_wdata_b;
    logic        grant_b, busy_b, tmo_b;

    dftm_sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .PRIO_P0(0), .MAX_WAIT(4), .TIMEOUT(8)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .p0_rd_i(p0_rd), .p0_wr_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
        .p0_data_o(p0_rdata), .p0_done_o(p0_done), .p0_err_o(p0_err),
        .p1_rd_i(p1_rd), .p1_wr_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
        .p1_data_o(p1_rdata), .p1_done_o(p1_done), .p1_err_o(p1_err),
        .sdram_rd_o(sd_rd), .sdram_wr_o(sd_wr), .sdram_addr_o(sd_addr), .sdram_data_o(sd_wdata),
        .sdram_data_i(sd_rdata), .sdram_done_i(sd_done),
        .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
    );

    dftm_sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .PRIO_P0(1), .MAX_WAIT(2), .TIMEOUT(8)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n_b),
        .p0_rd_i(1'b0), .p0_wr_i(p0_wr_b), .p0_addr_i(24'h000100), .p0_data_i(16'h0A0A),
        .p0_data_o(p0_rdata_b), .p0_done_o(p0_done_b), .p0_err_o(p0_err_b),
        .p1_rd_i(1'b0), .p1_wr_i(p1_wr_b), .p1_addr_i(24'h000200), .p1_data_i(16'h1B1B),
        .p1_data_o(p1_rdata_b), .p1_done_o(p1_done_b), .p1_err_o(p1_err_b),
        .sdram_rd_o(sd_rd_b), .sdram_wr_o(sd_wr_b), .sdram_addr_o(sd_addr_b), .sdram_data_o(sd_wdata_b),
        .sdram_data_i(16'h0000), .sdram_done_i(sd_done_b),
        .grant_o(grant_b), .busy_o(busy_b), .timeout_o(tmo_b)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    iss_t  iss_q[$];
    iss_t  iss_b_q[$];
    done_t done_q[$];
    int    b_issue_cnt = 0;
    bit    b_finished  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic iss_t mk_iss(input logic g, input logic rd, input logic wr,
                                    input logic [23:0] a, input logic [15:0] d);
        iss_t e;
        e.grant = g; e.rd = rd; e.wr = wr; e.addr = a; e.data = d;
        return e;
    endfunction

    function automatic done_t mk_done(input logic p, input logic [15:0] d, input logic err);
        done_t e;
        e.port = p; e.data = d; e.err = err;
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 64'({sd_rd, sd_wr, grant, busy, tmo, p0_done, p0_err, p1_done, p1_err}), 64'd0);
        check({tag, "_buses"}, 64'({sd_addr, sd_wdata, p0_rdata}), 64'd0);
        check({tag, "_p1data"}, 64'(p1_rdata), 64'd0);
    endtask

    // Waits (bounded) for a command on instance A, then returns done after lat cycles.
    task automatic serve(input int lat, input logic [15:0] rdata);
        int n = 0;
        while (!(sd_rd || sd_wr) && n < 64) begin
            tick();
            n++;
        end
        check("cmd_issued", 64'(sd_rd | sd_wr), 64'd1);
        if (!(sd_rd || sd_wr)) return;
        repeat (lat) tick();
        sd_rdata = rdata;
        sd_done  = 1'b1;
        tick();
        sd_done  = 1'b0;
    endtask

    // Monitor A: compare each new SDRAM command and each done pulse against the queues
    logic  cmd_prev = 1'b0;
    iss_t  mon_iss;
    done_t mon_done;
    always @(negedge clk) begin
        if ((sd_rd || sd_wr) && !cmd_prev) begin
            if (iss_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL issue_unexpected: grant=%0d addr=0x%0h", grant, sd_addr);
            end else begin
                mon_iss = iss_q.pop_front();
                check("issue", 64'({grant, sd_rd, sd_wr, sd_addr, sd_wdata}), 64'(mon_iss));
            end
        end
        cmd_prev = sd_rd | sd_wr;
        if (p0_done || p1_done) begin
            if (done_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL done_unexpected: p0_done=%0d p1_done=%0d", p0_done, p1_done);
            end else begin
                mon_done = done_q.pop_front();
                if (p1_done)
                    check("done_p1", 64'({1'b1, p1_rdata, p1_err}), 64'(mon_done));
                else
                    check("done_p0", 64'({1'b0, p0_rdata, p0_err}), 64'(mon_done));
            end
        end
    end

    // Instance B SDRAM: done one cycle after each command appears
    initial forever begin
        @(negedge clk);
        sd_done_b = (sd_rd_b || sd_wr_b) && !sd_done_b;
    end

    logic cmd_prev_b = 1'b0;
    iss_t mon_iss_b;
    always @(negedge clk) begin
        if ((sd_rd_b || sd_wr_b) && !cmd_prev_b) begin
            b_issue_cnt++;
            if (iss_b_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL prio_issue_unexpected: grant=%0d", grant_b);
            end else begin
                mon_iss_b = iss_b_q.pop_front();
                check("prio_issue", 64'({grant_b, sd_rd_b, sd_wr_b, sd_addr_b, sd_wdata_b}), 64'(mon_iss_b));
            end
        end
        cmd_prev_b = sd_rd_b | sd_wr_b;
    end

    initial begin : stim_b
        int n;
        logic order [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        #2 rst_n_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n_b = 1'b1;
        for (int i = 0; i < 6; i++)
            iss_b_q.push_back(mk_iss(order[i], 1'b0, 1'b1,
                                     order[i] ? 24'h000200 : 24'h000100,
                                     order[i] ? 16'h1B1B : 16'h0A0A));
        tick();
        p0_wr_b = 1'b1;
        p1_wr_b = 1'b1;
        n = 0;
        while (!(b_issue_cnt == 6 && (p0_done_b || p1_done_b)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("prio_last_done_seen", 64'(p1_done_b), 64'd1);
        p0_wr_b = 1'b0;
        p1_wr_b = 1'b0;
        b_finished = 1'b1;
    end

    initial begin : stim_a
        int cnt0, cnt1, hi, n;
        #2 rst_n = 1'b0;
        #10 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Round-robin: both ports write continuously, three transactions each
        for (int i = 0; i < 6; i++) begin
            iss_q.push_back(mk_iss(i[0], 1'b0, 1'b1, i[0] ? 24'h000020 : 24'h000010,
                                   i[0] ? 16'h2222 : 16'h1111));
            done_q.push_back(mk_done(i[0], 16'h0000, 1'b0));
        end
        p0_addr = 24'h000010; p0_wdata = 16'h1111; p0_wr = 1'b1;
        p1_addr = 24'h000020; p1_wdata = 16'h2222; p1_wr = 1'b1;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            serve(2, 16'h0000);
            if (grant) cnt1++; else cnt0++;
            if (cnt0 == 3) p0_wr = 1'b0;
            if (cnt1 == 3) p1_wr = 1'b0;
        end
        p1_wdata = 16'h0000;

        // Single p0 read, SDRAM answers 0xBEEF five cycles after the command
        tick();
        check("t1_idle_before", 64'(busy), 64'd0);
        iss_q.push_back(mk_iss(1'b0, 1'b1, 1'b0, 24'h001234, 16'h0000));
        done_q.push_back(mk_done(1'b0, 16'hBEEF, 1'b0));
        p0_wdata = 16'h0000; p0_addr = 24'h001234; p0_rd = 1'b1;
        hi = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (sd_rd && sd_addr == 24'h001234) hi++;
            if (c == 6) begin
                sd_rdata = 16'hBEEF;
                sd_done  = 1'b1;
            end
        end
        check("t1_rd_cycles_1_to_6", 64'(hi), 64'd6);
        tick();
        sd_done = 1'b0;
        check("t1_cmd_drop_cycle7", 64'(sd_rd), 64'd0);
        check("t1_done_cycle7", 64'({p0_done, p1_done}), 64'b10);
        tick();
        p0_rd = 1'b0;
        check("t1_p1_untouched", 64'({p1_done, p1_err, p1_rdata}), 64'd0);
        check("t1_data_held", 64'(p0_rdata), 64'hBEEF);

        // Spurious done in IDLE, then rd+wr together treated as a read
        tick();
        sd_rdata = 16'hDEAD;
        sd_done  = 1'b1;
        tick();
        sd_done  = 1'b0;
        check("spurious_no_done", 64'({p0_done, p1_done, busy}), 64'd0);
        check("spurious_data_kept", 64'(p0_rdata), 64'hBEEF);
        iss_q.push_back(mk_iss(1'b0, 1'b1, 1'b0, 24'h00ABCD, 16'h5555));
        done_q.push_back(mk_done(1'b0, 16'h0C0C, 1'b0));
        p0_addr = 24'h00ABCD; p0_wdata = 16'h5555; p0_rd = 1'b1; p0_wr = 1'b1;
        serve(2, 16'h0C0C);
        tick();
        p0_rd = 1'b0; p0_wr = 1'b0;

        // p1 read so that the later abort visibly clears p1 data
        iss_q.push_back(mk_iss(1'b1, 1'b1, 1'b0, 24'h000042, 16'h0000));
        done_q.push_back(mk_done(1'b1, 16'h7E57, 1'b0));
        p1_addr = 24'h000042; p1_rd = 1'b1;
        serve(1, 16'h7E57);
        tick();
        p1_rd = 1'b0;

        // Timeout: p1 read never completed
        iss_q.push_back(mk_iss(1'b1, 1'b1, 1'b0, 24'h00FFFF, 16'h0000));
        done_q.push_back(mk_done(1'b1, 16'h0000, 1'b1));
        p1_addr = 24'h00FFFF; p1_rd = 1'b1;
        n = 0;
        while (!sd_rd && n < 20) begin
            tick();
            n++;
        end
        hi = 0;
        while (sd_rd && hi < 40) begin
            hi++;
            tick();
        end
        check("tmo_cmd_cycles", 64'(hi), 64'd8);
        check("tmo_done_err_data", 64'({p1_done, p1_err, p1_rdata}), 64'({1'b1, 1'b1, 16'h0000}));
        check("tmo_sticky_set", 64'(tmo), 64'd1);
        tick();
        p1_rd = 1'b0;
        check("tmo_pulse_one_cycle", 64'({p1_done, p1_err, tmo}), 64'b001);
        iss_q.push_back(mk_iss(1'b0, 1'b0, 1'b1, 24'h000300, 16'h3333));
        done_q.push_back(mk_done(1'b0, 16'h0C0C, 1'b0));
        p0_addr = 24'h000300; p0_wdata = 16'h3333; p0_wr = 1'b1;
        serve(3, 16'h0000);
        tick();
        p0_wr = 1'b0;
        check("tmo_still_sticky", 64'(tmo), 64'd1);

        // Reset in the middle of a BUSY transaction: no done, outputs clear at once
        iss_q.push_back(mk_iss(1'b0, 1'b1, 1'b0, 24'h000777, 16'h3333));
        p0_addr = 24'h000777; p0_rd = 1'b1;
        n = 0;
        while (!sd_rd && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        p0_rd = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b1;
        tick();
        iss_q.push_back(mk_iss(1'b0, 1'b0, 1'b1, 24'h000500, 16'h5A5A));
        done_q.push_back(mk_done(1'b0, 16'h0000, 1'b0));
        iss_q.push_back(mk_iss(1'b1, 1'b0, 1'b1, 24'h000600, 16'h6B6B));
        done_q.push_back(mk_done(1'b1, 16'h0000, 1'b0));
        p0_addr = 24'h000500; p0_wdata = 16'h5A5A; p0_wr = 1'b1;
        p1_addr = 24'h000600; p1_wdata = 16'h6B6B; p1_wr = 1'b1;
        serve(1, 16'h0000);
        p0_wr = 1'b0;
        serve(1, 16'h0000);
        tick();
        p1_wr = 1'b0;

        repeat (5) tick();
        n = 0;
        while (!b_finished && n < 1000) begin
            tick();
            n++;
        end
        check("prio_finished", 64'(b_finished), 64'd1);
        check("prio_issue_count", 64'(b_issue_cnt), 64'd6);
        check("issue_queue_drained", 64'(iss_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);
        check("prio_queue_drained", 64'(iss_b_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
